dcsk_rx_word_buffer: RTL and testbench

Downstream of the receiver demodulation FSM. Collects serially demodulated bits into `WORD_W`-bit words at the addresses the FSM supplies. On each word-complete strobe, it pushes the word into a small first-word-fall-through FIFO. The FIFO is drained by the consumer through a valid/ready handshake, and the block flags overflow and malformed words.

---
 rtl/dcsk_rx_word_buffer_if.sv | 29 ++
 rtl/dcsk_rx_word_buffer.sv | 134 +++++++++++++
 tb/tb_dcsk_rx_word_buffer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcsk_rx_word_buffer_if.sv
// Bit-assembly inputs and word-FIFO drain handshake of the DCSK receive word buffer.
// master drives bits and consumes words; slave is the buffer itself.
interface dcsk_rx_word_buffer_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
);
    logic                       Bit_Load;
    logic [ADDR_W-1:0]          Bit_Addr;
    logic                       Demod_Bit;
    logic                       Word_Done;
    logic                       Flush;
    logic                       Out_Ready;
    logic                       Out_Valid;
    logic [WORD_W-1:0]          Out_Data;
    logic [$clog2(DEPTH):0]     Level;
    logic                       Overflow;
    logic                       Frame_Err;

    modport master (
        output Bit_Load, Bit_Addr, Demod_Bit, Word_Done, Flush, Out_Ready,
        input  Out_Valid, Out_Data, Level, Overflow, Frame_Err
    );

    modport slave (
        input  Bit_Load, Bit_Addr, Demod_Bit, Word_Done, Flush, Out_Ready,
        output Out_Valid, Out_Data, Level, Overflow, Frame_Err
    );
endinterface

// File: rtl/dcsk_rx_word_buffer.sv
// Assembles demodulated bits into words and queues them in a first-word-fall-through FIFO,
// flagging dropped words (overflow) and words committed with the wrong bit count.
module dcsk_rx_word_buffer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input logic                  Clk,
    input logic                  Rst,
    dcsk_rx_word_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_W + 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(DEPTH);

    typedef enum logic [1:0] {StEmpty, StNonEmpty, StFull} fifo_state_e;

    logic [WORD_W-1:0] asm_q, asm_d, asm_bypass;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              push, pop, wr_en, rd_en;
    fifo_state_e       fifo_state;

    // Same-cycle load is folded into the word so a commit on the last bit loses nothing.
    always_comb begin
        asm_bypass = asm_q;
        cnt_eff    = cnt_q;
        if (bus.Bit_Load) begin
            asm_bypass[bus.Bit_Addr] = bus.Demod_Bit;
            if (cnt_q != CNT_SAT) cnt_eff = cnt_q + 1'b1;
        end
    end

    always_comb begin
        asm_d       = asm_bypass;
        cnt_d       = cnt_eff;
        frame_err_d = frame_err_q;
        if (bus.Flush) begin
            asm_d       = '0;
            cnt_d       = '0;
            frame_err_d = 1'b0;
        end else if (bus.Word_Done) begin
            asm_d = '0;
            cnt_d = '0;
            if (cnt_eff != CNT_FULL) frame_err_d = 1'b1;
        end
    end

    always_comb begin
        fifo_state = StNonEmpty;
        if (level_q == '0) fifo_state = StEmpty;
        else if (level_q == LVL_MAX) fifo_state = StFull;
    end

    assign push = bus.Word_Done;
    assign pop  = (level_q != '0) && bus.Out_Ready;

    always_comb begin
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        overflow_d = overflow_q;
        case (fifo_state)
            StEmpty: wr_en = push;
            StNonEmpty: begin
                wr_en = push;
                rd_en = pop;
            end
            StFull: begin
                // A simultaneous pop frees the slot the push needs.
                rd_en = pop;
                wr_en = push & pop;
                if (push && !pop) overflow_d = 1'b1;
            end
            default: ;
        endcase
        if (bus.Flush) begin
            wr_en      = 1'b0;
            rd_en      = 1'b0;
            overflow_d = 1'b0;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !rd_en) level_d = level_q + 1'b1;
        else if (rd_en && !wr_en) level_d = level_q - 1'b1;
        if (bus.Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= asm_bypass;
        end
    end

    assign bus.Out_Valid = (level_q != '0);
    assign bus.Out_Data  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.Level     = level_q;
    assign bus.Overflow  = overflow_q;
    assign bus.Frame_Err = frame_err_q;
endmodule

// File: tb/tb_dcsk_rx_word_buffer.sv
// Bench for dcsk_rx_word_buffer: directed scenarios plus random traffic against a queue-based
// model of word assembly, FIFO occupancy and sticky flags.
module tb_dcsk_rx_word_buffer;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_asm;
    int          m_cnt;
    bit          m_ovf, m_ferr;

    dcsk_rx_word_buffer_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    dcsk_rx_word_buffer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_q.delete();
        m_asm = '0;
        m_cnt = 0;
        m_ovf = 0;
        m_ferr = 0;
    endtask

    // Advance the model with the current inputs, then cross the clock edge.
    task automatic tick();
        logic [31:0] w;
        int n;
        bit do_pop;
        do_pop = (m_q.size() != 0) && bus.Out_Ready;
        if (bus.Flush) begin
            model_reset();
        end else begin
            w = m_asm;
            n = m_cnt;
            if (bus.Bit_Load) begin
                w[bus.Bit_Addr] = bus.Demod_Bit;
                n = (n + 1 > 33) ? 33 : n + 1;
            end
            if (bus.Word_Done) begin
                if (n != 32) m_ferr = 1;
                m_asm = '0;
                m_cnt = 0;
            end else begin
                m_asm = w;
                m_cnt = n;
            end
            if (do_pop) void'(m_q.pop_front());
            if (bus.Word_Done) begin
                if (m_q.size() < DEPTH) m_q.push_back(w);
                else m_ovf = 1;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic load_bits(input logic [31:0] w, input int n, input bit done_on_last);
        for (int i = 0; i < n; i++) begin
            bus.Bit_Load  = 1'b1;
            bus.Bit_Addr  = 5'(i % 32);
            bus.Demod_Bit = w[i%32];
            bus.Word_Done = done_on_last && (i == n - 1);
            tick();
        end
        bus.Bit_Load  = 1'b0;
        bus.Word_Done = 1'b0;
    endtask

    task automatic commit();
        bus.Word_Done = 1'b1;
        tick();
        bus.Word_Done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        load_bits(w, 32, 1'b0);
        commit();
    endtask

    task automatic do_flush();
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (bus.Out_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.Out_Valid); end
        total++; if (bus.Out_Data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.Out_Data); end
        total++; if (bus.Level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", bus.Level); end
        total++; if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", bus.Overflow); end
        total++; if (bus.Frame_Err !== 1'b0) begin bad++; $display("FAIL rst_ferr: got %b want 0", bus.Frame_Err); end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();
        tick();
        total++; if (bus.Level !== 3'd0) begin bad++; $display("FAIL rst_idle_level: got %0d want 0", bus.Level); end
    endtask

    task automatic test_single_word();
        bus.Out_Ready = 1'b1;
        send_word(32'hAAAA_AAAA);
        total++; if (bus.Out_Valid !== 1'b1) begin bad++; $display("FAIL sw_valid: got %b want 1", bus.Out_Valid); end
        total++; if (bus.Out_Data !== 32'hAAAA_AAAA) begin bad++; $display("FAIL sw_data: got %h want aaaaaaaa", bus.Out_Data); end
        tick();
        total++; if (bus.Level !== 3'd0) begin bad++; $display("FAIL sw_level: got %0d want 0", bus.Level); end
        total++; if (bus.Out_Valid !== 1'b0) begin bad++; $display("FAIL sw_drain: got %b want 0", bus.Out_Valid); end
        total++; if (bus.Frame_Err !== 1'b0) begin bad++; $display("FAIL sw_ferr: got %b want 0", bus.Frame_Err); end
        bus.Out_Ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        do_flush();
        bus.Out_Ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_word(32'(k));
        total++; if (bus.Level !== 3'd4) begin bad++; $display("FAIL bp_level: got %0d want 4", bus.Level); end
        total++; if (bus.Out_Data !== 32'h1) begin bad++; $display("FAIL bp_head: got %h want 1", bus.Out_Data); end
        send_word(32'h5);
        total++; if (bus.Overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf: got %b want 1", bus.Overflow); end
        total++; if (bus.Level !== 3'd4) begin bad++; $display("FAIL bp_level_ovf: got %0d want 4", bus.Level); end
        total++; if (bus.Out_Data !== 32'h1) begin bad++; $display("FAIL bp_stable: got %h want 1", bus.Out_Data); end
        bus.Out_Ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            total++; if (bus.Out_Data !== 32'(k)) begin bad++; $display("FAIL bp_order%0d: got %h want %h", k, bus.Out_Data, 32'(k)); end
            tick();
        end
        total++; if (bus.Out_Valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", bus.Out_Valid); end
        total++; if (bus.Overflow !== 1'b1) begin bad++; $display("FAIL bp_sticky: got %b want 1", bus.Overflow); end
        bus.Out_Ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_flush();
        bus.Out_Ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_word(32'(k));
        load_bits(32'h9, 32, 1'b0);
        bus.Out_Ready = 1'b1;
        commit();
        bus.Out_Ready = 1'b0;
        total++; if (bus.Level !== 3'd4) begin bad++; $display("FAIL fpp_level: got %0d want 4", bus.Level); end
        total++; if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf: got %b want 0", bus.Overflow); end
        bus.Out_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp;
            exp = (k == 3) ? 32'h9 : 32'(k + 2);
            total++; if (bus.Out_Data !== exp) begin bad++; $display("FAIL fpp_order%0d: got %h want %h", k, bus.Out_Data, exp); end
            tick();
        end
        total++; if (bus.Level !== 3'd0) begin bad++; $display("FAIL fpp_drain: got %0d want 0", bus.Level); end
        bus.Out_Ready = 1'b0;
    endtask

    task automatic test_short_word();
        do_flush();
        total++; if (bus.Frame_Err !== 1'b0) begin bad++; $display("FAIL sh_pre: got %b want 0", bus.Frame_Err); end
        load_bits(32'hFFFF_FFFF, 10, 1'b0);
        commit();
        total++; if (bus.Frame_Err !== 1'b1) begin bad++; $display("FAIL sh_ferr: got %b want 1", bus.Frame_Err); end
        total++; if (bus.Out_Data !== 32'h0000_03FF) begin bad++; $display("FAIL sh_data: got %h want 000003ff", bus.Out_Data); end
        bus.Out_Ready = 1'b1;
        tick();
        bus.Out_Ready = 1'b0;
        send_word(32'h1234_5678);
        total++; if (bus.Out_Data !== 32'h1234_5678) begin bad++; $display("FAIL sh_next: got %h want 12345678", bus.Out_Data); end
        total++; if (bus.Frame_Err !== 1'b1) begin bad++; $display("FAIL sh_sticky: got %b want 1", bus.Frame_Err); end
        do_flush();
        // 96 loads: a counter that wrapped instead of saturating would read 32 again.
        load_bits(32'h0, 96, 1'b0);
        commit();
        total++; if (bus.Frame_Err !== 1'b1) begin bad++; $display("FAIL sh_sat: got %b want 1", bus.Frame_Err); end
    endtask

    task automatic test_bypass();
        do_flush();
        bus.Out_Ready = 1'b0;
        load_bits(32'h8000_0F0F, 32, 1'b1);
        total++; if (bus.Out_Data !== 32'h8000_0F0F) begin bad++; $display("FAIL bp_word: got %h want 80000f0f", bus.Out_Data); end
        total++; if (bus.Frame_Err !== 1'b0) begin bad++; $display("FAIL byp_ferr: got %b want 0", bus.Frame_Err); end
        bus.Out_Ready = 1'b1;
        tick();
        bus.Out_Ready = 1'b0;
        bus.Bit_Load  = 1'b1;
        bus.Bit_Addr  = 5'd5;
        bus.Demod_Bit = 1'b0;
        commit();
        bus.Bit_Load  = 1'b0;
        total++; if (bus.Out_Data !== 32'h0) begin bad++; $display("FAIL byp_clear: got %h want 0", bus.Out_Data); end
    endtask

    task automatic test_flush_reset();
        do_flush();
        bus.Out_Ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_word(32'(k + 16));
        bus.Out_Ready = 1'b1;
        tick();
        tick();
        bus.Out_Ready = 1'b0;
        total++; if (bus.Level !== 3'd2) begin bad++; $display("FAIL fl_level: got %0d want 2", bus.Level); end
        total++; if (bus.Overflow !== 1'b1) begin bad++; $display("FAIL fl_ovf: got %b want 1", bus.Overflow); end
        do_flush();
        total++; if ({bus.Out_Valid, bus.Out_Data, bus.Level, bus.Overflow, bus.Frame_Err} !== 38'h0) begin
            bad++; $display("FAIL fl_clear: got v=%b d=%h l=%0d o=%b f=%b want all 0",
                            bus.Out_Valid, bus.Out_Data, bus.Level, bus.Overflow, bus.Frame_Err);
        end
        send_word(32'hCAFE_F00D);
        load_bits(32'hFFFF, 10, 1'b0);
        Rst = 1'b1;
        #2;
        total++; if ({bus.Out_Valid, bus.Out_Data, bus.Level, bus.Overflow, bus.Frame_Err} !== 38'h0) begin
            bad++; $display("FAIL rst_mid: got v=%b d=%h l=%0d o=%b f=%b want all 0",
                            bus.Out_Valid, bus.Out_Data, bus.Level, bus.Overflow, bus.Frame_Err);
        end
        #2;
        Rst = 1'b0;
        model_reset();
        send_word(32'h0BAD_BEEF);
        total++; if (bus.Out_Data !== 32'h0BAD_BEEF) begin bad++; $display("FAIL rst_word: got %h want 0badbeef", bus.Out_Data); end
        total++; if (bus.Frame_Err !== 1'b0) begin bad++; $display("FAIL rst_ferr2: got %b want 0", bus.Frame_Err); end
    endtask

    task automatic test_random();
        logic [31:0] exp_data;
        do_flush();
        for (int c = 0; c < 600; c++) begin
            bus.Bit_Load  = ($urandom_range(0, 3) != 0);
            bus.Bit_Addr  = 5'($urandom_range(0, 31));
            bus.Demod_Bit = 1'($urandom_range(0, 1));
            bus.Word_Done = ($urandom_range(0, 29) == 0);
            bus.Out_Ready = ($urandom_range(0, 2) == 0);
            bus.Flush     = ($urandom_range(0, 199) == 0);
            tick();
            exp_data = (m_q.size() != 0) ? m_q[0] : 32'h0;
            total++; if (bus.Out_Valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.Out_Valid, m_q.size() != 0); end
            total++; if (bus.Out_Data !== exp_data) begin bad++; $display("FAIL rnd_data@%0d: got %h want %h", c, bus.Out_Data, exp_data); end
            total++; if (bus.Level !== 3'(m_q.size())) begin bad++; $display("FAIL rnd_level@%0d: got %0d want %0d", c, bus.Level, m_q.size()); end
            total++; if (bus.Overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, bus.Overflow, m_ovf); end
            total++; if (bus.Frame_Err !== m_ferr) begin bad++; $display("FAIL rnd_ferr@%0d: got %b want %b", c, bus.Frame_Err, m_ferr); end
        end
        bus.Bit_Load  = 1'b0;
        bus.Word_Done = 1'b0;
        bus.Out_Ready = 1'b0;
        bus.Flush     = 1'b0;
    endtask

    initial begin
        bus.Bit_Load  = 1'b0;
        bus.Bit_Addr  = '0;
        bus.Demod_Bit = 1'b0;
        bus.Word_Done = 1'b0;
        bus.Flush     = 1'b0;
        bus.Out_Ready = 1'b0;
        model_reset();
        test_reset();
        test_single_word();
        test_back_pressure();
        test_full_push_pop();
        test_short_word();
        test_bypass();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
